// File: rtl/store_issue.sv
// store_issue: memory-stage store path.
//   Accepts one store (byte/half/word) at a time from the pipeline. It checks the
//   alignment, builds the byte strobes and lane-replicated write data, and runs an
//   addr_ok/data_ok handshake on the data bus. It reports completion or an address
//   error back to the pipeline.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         pipeline store handshake (accept = valid & ready & ~flush)
//   req_addr/req_data/req_size  store address, right-aligned data, size (00 B, 01 H, 10 W)
//   flush                       kills the store offered in the same cycle
//   dreq_valid/addr/strobe/data/size  registered bus request
//   dresp_addr_ok/dresp_data_ok bus address-accept / write-complete
//   done, exc_ades, badvaddr    completion pulse, address error, faulting address
//   store_cnt                   count of stores completed on the bus (wraps)
module store_issue #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_size,
  input  logic             flush,
  output logic             dreq_valid,
  output logic [31:0]      dreq_addr,
  output logic [3:0]       dreq_strobe,
  output logic [31:0]      dreq_data,
  output logic [1:0]       dreq_size,
  input  logic             dresp_addr_ok,
  input  logic             dresp_data_ok,
  output logic             done,
  output logic             exc_ades,
  output logic [31:0]      badvaddr,
  output logic [CNT_W-1:0] store_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_EXC} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         strobe_q, strobe_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         size_q, size_d;
  logic               done_q, done_d;
  logic               exc_q, exc_d;
  logic [31:0]        badv_q, badv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               misalign;
  logic [3:0]         strobe_c;
  logic [31:0]        data_c;

  always_comb begin
    accept = req_valid & (state_q == S_IDLE) & ~flush;

    misalign = 1'b0;
    strobe_c = '0;
    data_c   = '0;
    case (req_size)
      2'b00: begin
        strobe_c = 4'b0001 << req_addr[1:0];
        data_c   = {4{req_data[7:0]}};
      end
      2'b01: begin
        misalign = req_addr[0];
        strobe_c = req_addr[1] ? 4'b1100 : 4'b0011;
        data_c   = {2{req_data[15:0]}};
      end
      2'b10: begin
        misalign = |req_addr[1:0];
        strobe_c = 4'b1111;
        data_c   = req_data;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    size_d   = size_q;
    done_d   = 1'b0;
    exc_d    = 1'b0;
    badv_d   = badv_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = S_EXC;
            done_d  = 1'b1;
            exc_d   = 1'b1;
            badv_d  = req_addr;
          end else begin
            state_d  = S_ADDR;
            addr_d   = {req_addr[31:2], 2'b00};
            strobe_d = strobe_c;
            data_d   = data_c;
            size_d   = req_size;
          end
        end
      end
      S_ADDR: begin
        if (dresp_addr_ok) begin
          // Both handshakes in one cycle skip DATA entirely.
          if (dresp_data_ok) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (dresp_data_ok) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE; // S_EXC: the done/exc pulse is shown for this one cycle
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      size_q   <= '0;
      done_q   <= 1'b0;
      exc_q    <= 1'b0;
      badv_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      size_q   <= size_d;
      done_q   <= done_d;
      exc_q    <= exc_d;
      badv_q   <= badv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign dreq_valid  = (state_q == S_ADDR);
  assign dreq_addr   = addr_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = data_q;
  assign dreq_size   = size_q;
  assign done        = done_q;
  assign exc_ades    = exc_q;
  assign badvaddr    = badv_q;
  assign store_cnt   = cnt_q;

endmodule

// File: tb/tb_store_issue.sv
module tb_store_issue;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_size;
  logic             flush;
  logic             dreq_valid;
  logic [31:0]      dreq_addr;
  logic [3:0]       dreq_strobe;
  logic [31:0]      dreq_data;
  logic [1:0]       dreq_size;
  logic             dresp_addr_ok;
  logic             dresp_data_ok;
  logic             done;
  logic             exc_ades;
  logic [31:0]      badvaddr;
  logic [CNT_W-1:0] store_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  store_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dreq_size(dreq_size),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .done(done), .exc_ades(exc_ades), .badvaddr(badvaddr), .store_cnt(store_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #2;
    checks++;
    if ({req_ready, dreq_valid, done, exc_ades} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b want 1000", {req_ready, dreq_valid, done, exc_ades});
    end
    checks++;
    if ({dreq_addr, dreq_strobe, dreq_data, dreq_size, badvaddr, store_cnt} !== '0) begin
      errors++; $display("FAIL reset_fields addr=%h strb=%b data=%h size=%b badv=%h cnt=%0d want all 0",
                         dreq_addr, dreq_strobe, dreq_data, dreq_size, badvaddr, store_cnt);
    end
    #10 resetn = 1'b1;
    tick();
  endtask

  task automatic test_sb_fast();
    req_valid = 1'b1; req_addr = 32'h0000_1003; req_data = 32'h0000_00AB; req_size = 2'b00;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL sb_ready got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    checks++;
    if ({dreq_valid, done} !== 2'b10) begin
      errors++; $display("FAIL sb_c1_ctrl got %b want 10", {dreq_valid, done});
    end
    checks++;
    if (dreq_strobe !== 4'b1000) begin errors++; $display("FAIL sb_strobe got %b want 1000", dreq_strobe); end
    checks++;
    if (dreq_data !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_data got %h want ababab", dreq_data); end
    checks++;
    if ({dreq_addr, dreq_size} !== {32'h0000_1000, 2'b00}) begin
      errors++; $display("FAIL sb_addr got %h/%b want 00001000/00", dreq_addr, dreq_size);
    end
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if ({done, exc_ades, req_ready, dreq_valid} !== 4'b1010) begin
      errors++; $display("FAIL sb_done got %b want 1010", {done, exc_ades, req_ready, dreq_valid});
    end
    checks++;
    if (store_cnt !== exp_cnt) begin errors++; $display("FAIL sb_cnt got %0d want %0d", store_cnt, exp_cnt); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL sb_done_drop got %b want 0", done); end
  endtask

  task automatic test_sh_wait();
    req_valid = 1'b1; req_addr = 32'h0000_2002; req_data = 32'hFFFF_1234; req_size = 2'b01;
    tick();
    req_valid = 1'b0; req_data = '0; req_addr = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data, dreq_size, done} !==
          {1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234, 2'b01, 1'b0}) begin
        errors++; $display("FAIL sh_hold[%0d] v=%b a=%h s=%b d=%h z=%b done=%b want 1/00002000/1100/12341234/01/0",
                           i, dreq_valid, dreq_addr, dreq_strobe, dreq_data, dreq_size, done);
      end
      if (i == 3) dresp_addr_ok = 1'b1;
      tick();
    end
    dresp_addr_ok = 1'b0;
    checks++;
    if ({dreq_valid, done, req_ready} !== 3'b000) begin
      errors++; $display("FAIL sh_data1 got %b want 000", {dreq_valid, done, req_ready});
    end
    tick();
    dresp_data_ok = 1'b1;
    checks++;
    if ({dreq_valid, done} !== 2'b00) begin errors++; $display("FAIL sh_data2 got %b want 00", {dreq_valid, done}); end
    tick();
    dresp_data_ok = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if ({done, exc_ades, req_ready} !== 3'b101 || store_cnt !== exp_cnt) begin
      errors++; $display("FAIL sh_done got %b cnt=%0d want 101 cnt=%0d", {done, exc_ades, req_ready}, store_cnt, exp_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL sh_single_pulse got %b want 0", done); end
  endtask

  task automatic test_misalign();
    req_valid = 1'b1; req_addr = 32'h0000_3001; req_data = 32'h1111_2222; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({dreq_valid, done, exc_ades, req_ready} !== 4'b0110) begin
      errors++; $display("FAIL sw_exc got %b want 0110", {dreq_valid, done, exc_ades, req_ready});
    end
    checks++;
    if (badvaddr !== 32'h0000_3001) begin errors++; $display("FAIL sw_badv got %h want 00003001", badvaddr); end
    checks++;
    if (store_cnt !== exp_cnt) begin errors++; $display("FAIL sw_cnt got %0d want %0d", store_cnt, exp_cnt); end
    tick();
    checks++;
    if ({dreq_valid, done, exc_ades, req_ready} !== 4'b0001) begin
      errors++; $display("FAIL sw_after got %b want 0001", {dreq_valid, done, exc_ades, req_ready});
    end
  endtask

  task automatic test_flush();
    req_valid = 1'b1; flush = 1'b1; req_addr = 32'h0000_4000; req_data = 32'hDEAD_BEEF; req_size = 2'b10;
    tick();
    checks++;
    if ({dreq_valid, req_ready, done} !== 3'b010) begin
      errors++; $display("FAIL flush_kill got %b want 010", {dreq_valid, req_ready, done});
    end
    flush = 1'b0;
    tick();
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    checks++;
    if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data} !== {1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL flush_reissue v=%b a=%h s=%b d=%h want 1/00004000/1111/deadbeef",
                         dreq_valid, dreq_addr, dreq_strobe, dreq_data);
    end
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (done !== 1'b1 || store_cnt !== exp_cnt) begin
      errors++; $display("FAIL flush_done done=%b cnt=%0d want 1 cnt=%0d", done, store_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_in_data();
    req_valid = 1'b1; req_addr = 32'h0000_5001; req_data = 32'h0000_005A; req_size = 2'b00;
    tick();
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    checks++;
    if (dreq_strobe !== 4'b0010 || dreq_data !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL rst_pre s=%b d=%h want 0010/5a5a5a5a", dreq_strobe, dreq_data);
    end
    tick();
    dresp_addr_ok = 1'b0;
    #1 resetn = 1'b0;
    #1;
    exp_cnt = '0;
    checks++;
    if ({req_ready, dreq_valid, done, exc_ades} !== 4'b1000 ||
        {dreq_addr, dreq_strobe, dreq_data, dreq_size, badvaddr, store_cnt} !== '0) begin
      errors++; $display("FAIL rst_async ctrl=%b a=%h s=%b d=%h badv=%h cnt=%0d want 1000 and zeros",
                         {req_ready, dreq_valid, done, exc_ades}, dreq_addr, dreq_strobe, dreq_data, badvaddr, store_cnt);
    end
    #1 resetn = 1'b1;
    tick();
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if ({done, req_ready} !== 2'b01 || store_cnt !== '0) begin
      errors++; $display("FAIL rst_stray done=%b ready=%b cnt=%0d want 0/1/0", done, req_ready, store_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 32'h0000_6000 + 32'(i * 4); req_data = 32'(i); req_size = 2'b10;
      tick();
      req_valid = 1'b0; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      checks++;
      if (dreq_valid !== 1'b1 || dreq_data !== 32'(i)) begin
        errors++; $display("FAIL b2b_req[%0d] v=%b d=%h want 1/%h", i, dreq_valid, dreq_data, 32'(i));
      end
      tick();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (done !== 1'b1 || req_ready !== 1'b1 || store_cnt !== exp_cnt) begin
        errors++; $display("FAIL b2b_done[%0d] done=%b ready=%b cnt=%0d want 1/1/%0d", i, done, req_ready, store_cnt, exp_cnt);
      end
    end
    checks++;
    if (store_cnt !== 4'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", store_cnt); end
    dresp_data_ok = 1'b1;
    tick();
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if ({done, dreq_valid, req_ready} !== 3'b001 || store_cnt !== 4'd0) begin
      errors++; $display("FAIL idle_spurious got %b cnt=%0d want 001 cnt=0", {done, dreq_valid, req_ready}, store_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sb_fast();
    test_sh_wait();
    test_misalign();
    test_flush();
    test_reset_in_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
